// File: rtl/merge_board_seq_pkg.sv
// Shared definitions for the sequential 2048 slide-and-merge engine.
// Holds board geometry, direction codes, FSM states and the helpers that map
// a (direction, line, position) triple onto a board cell index.
package merge_board_seq_pkg;

   localparam int CELL_W    = 5;
   localparam int NUM_CELLS = 16;
   localparam int BOARD_W   = NUM_CELLS * CELL_W;
   // One line holds at most two merges of exponent 30 -> 2*2^31 = 2^32.
   localparam int LSCORE_W  = 34;

   localparam logic [CELL_W-1:0] EXP_MAX = '1;

   typedef logic [NUM_CELLS-1:0][CELL_W-1:0] board_t;
   typedef logic [3:0][CELL_W-1:0]           line_t;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_UP    = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      S_IDLE, S_L0, S_L1, S_L2, S_L3, S_DONE
   } state_e;

   function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

   // Position p counts from the destination edge outward; ~p is 3-p.
   function automatic logic [3:0] line_pos(input dir_e d, input logic [1:0] k,
                                           input logic [1:0] p);
      case (d)
         DIR_RIGHT: return idx(k, ~p);
         DIR_UP:    return idx(p, k);
         DIR_DOWN:  return idx(~p, k);
         default:   return idx(k, p);
      endcase
   endfunction

endpackage

// File: rtl/merge_board_seq_line_merge4.sv
// Combinational slide-and-merge of one 4-cell line toward index 0.
//   cells_i : line cells, index 0 is the destination edge
//   cells_o : line after compress + single-pass pair merge
//   score_o : sum of 2^(n+1) for every merged exponent-n pair
//   max_o   : largest exponent in cells_o
import merge_board_seq_pkg::*;

module line_merge4 (
   input  logic [3:0][CELL_W-1:0] cells_i,
   output logic [3:0][CELL_W-1:0] cells_o,
   output logic [LSCORE_W-1:0]    score_o,
   output logic [CELL_W-1:0]      max_o
);

   line_t comp;
   int    k, j, o;

   always_comb begin
      comp    = '0;
      cells_o = '0;
      score_o = '0;
      max_o   = '0;
      k = 0;
      j = 0;
      o = 0;
      for (int i = 0; i < 4; i++) begin
         if (cells_i[i] != '0) begin
            comp[k] = cells_i[i];
            k++;
         end
      end
      // Read pointer j skips past both cells of a merge, so a merged result
      // is never considered again. Exponent 31 is left alone.
      for (int s = 0; s < 4; s++) begin
         if (j < 4) begin
            if (j < 3 && comp[j] != '0 && comp[j] == comp[j+1] && comp[j] != EXP_MAX) begin
               cells_o[o] = comp[j] + CELL_W'(1);
               score_o    = score_o + (LSCORE_W'(1) << (comp[j] + CELL_W'(1)));
               j = j + 2;
            end else begin
               cells_o[o] = comp[j];
               j = j + 1;
            end
            o++;
         end
      end
      for (int i = 0; i < 4; i++)
         if (cells_o[i] > max_o) max_o = cells_o[i];
   end

endmodule

// File: rtl/merge_board_seq.sv
// Sequential 2048 move engine: one line of the captured board per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start, dir : move request (sampled in IDLE) and direction
//   board_in   : filled board, cell i = row*4+col at bits [5i+4:5i]
//   busy, done : busy during the four line cycles, done pulses one cycle
//   board_out, movable, score_gain, max_tile : move results, valid from done
import merge_board_seq_pkg::*;

module merge_board_seq #(
   parameter int SCORE_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         dir,
   input  logic [BOARD_W-1:0] board_in,
   output logic               busy,
   output logic               done,
   output logic [BOARD_W-1:0] board_out,
   output logic               movable,
   output logic [SCORE_W-1:0] score_gain,
   output logic [CELL_W-1:0]  max_tile
);

   localparam int SUM_W = ((SCORE_W > LSCORE_W) ? SCORE_W : LSCORE_W) + 1;

   state_e              state_q, state_d;
   dir_e                dir_q, dir_d;
   board_t              cap_q, cap_d;
   board_t              work_q, work_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic [CELL_W-1:0]   maxacc_q, maxacc_d;
   board_t              bout_q, bout_d;
   logic                mov_q, mov_d;
   logic [CELL_W-1:0]   mtile_q, mtile_d;

   logic [1:0]          lk;
   logic [3:0][3:0]     pos;
   line_t               lin, lout;
   logic [LSCORE_W-1:0] lscore;
   logic [CELL_W-1:0]   lmax, maxl;
   logic [SUM_W-1:0]    sum;
   logic [SCORE_W-1:0]  score_sat;
   board_t              wb;

   line_merge4 u_merge (
      .cells_i (lin),
      .cells_o (lout),
      .score_o (lscore),
      .max_o   (lmax)
   );

   always_comb begin
      case (state_q)
         S_L1:    lk = 2'd1;
         S_L2:    lk = 2'd2;
         S_L3:    lk = 2'd3;
         default: lk = 2'd0;
      endcase
   end

   // Gather the active line and scatter the merged result back in place.
   always_comb begin
      pos = '0;
      lin = '0;
      wb  = work_q;
      for (int p = 0; p < 4; p++) begin
         pos[p] = line_pos(dir_q, lk, 2'(p));
         lin[p] = work_q[pos[p]];
      end
      for (int p = 0; p < 4; p++)
         wb[pos[p]] = lout[p];
   end

   assign sum       = SUM_W'(score_q) + SUM_W'(lscore);
   assign score_sat = (sum > SUM_W'({SCORE_W{1'b1}})) ? '1 : sum[SCORE_W-1:0];
   assign maxl      = (lmax > maxacc_q) ? lmax : maxacc_q;

   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      cap_d    = cap_q;
      work_d   = work_q;
      score_d  = score_q;
      maxacc_d = maxacc_q;
      bout_d   = bout_q;
      mov_d    = mov_q;
      mtile_d  = mtile_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cap_d    = board_in;
               work_d   = board_in;
               dir_d    = dir_e'(dir);
               score_d  = '0;
               maxacc_d = '0;
               mov_d    = 1'b0;
               state_d  = S_L0;
            end
         end
         S_L0, S_L1, S_L2: begin
            work_d   = wb;
            score_d  = score_sat;
            maxacc_d = maxl;
            state_d  = (state_q == S_L0) ? S_L1 : (state_q == S_L1) ? S_L2 : S_L3;
         end
         S_L3: begin
            // Results are registered here so they are visible during DONE.
            work_d   = wb;
            score_d  = score_sat;
            maxacc_d = maxl;
            bout_d   = wb;
            mov_d    = (wb != cap_q);
            mtile_d  = maxl;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         dir_q    <= DIR_LEFT;
         cap_q    <= '0;
         work_q   <= '0;
         score_q  <= '0;
         maxacc_q <= '0;
         bout_q   <= '0;
         mov_q    <= 1'b0;
         mtile_q  <= '0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         cap_q    <= cap_d;
         work_q   <= work_d;
         score_q  <= score_d;
         maxacc_q <= maxacc_d;
         bout_q   <= bout_d;
         mov_q    <= mov_d;
         mtile_q  <= mtile_d;
      end
   end

   assign busy       = (state_q == S_L0) || (state_q == S_L1) ||
                       (state_q == S_L2) || (state_q == S_L3);
   assign done       = (state_q == S_DONE);
   assign board_out  = bout_q;
   assign movable    = mov_q;
   assign score_gain = score_q;
   assign max_tile   = mtile_q;

endmodule

// File: tb/tb_merge_board_seq.sv
module tb_merge_board_seq;

   typedef logic [15:0][4:0] brd_t;

   typedef struct {
      brd_t        b;
      logic        mov;
      logic [31:0] sc;
      logic [4:0]  mx;
   } res_t;

   typedef struct {
      logic [1:0] d;
      brd_t       bin;
      res_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [1:0]  dir;
   logic [79:0] board_in;
   logic        busy, done, movable;
   logic [79:0] board_out;
   logic [31:0] score_gain;
   logic [4:0]  max_tile;

   int   n_cmp = 0, n_bad = 0;
   int   ph = 0, n_acc = 0;
   bit   mon_en = 0;
   res_t sbq[$];
   res_t last, pend;
   vec_t tv[9];

   merge_board_seq #(.SCORE_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .dir(dir), .board_in(board_in),
      .busy(busy), .done(done), .board_out(board_out), .movable(movable),
      .score_gain(score_gain), .max_tile(max_tile)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference move: walks non-empty cells, holding one pending tile that
   // either merges with the next equal tile or is emitted.
   function automatic res_t model(input brd_t b, input logic [1:0] d);
      res_t   r;
      longint sc = 0;
      r.b = b;
      for (int k = 0; k < 4; k++) begin
         int ci[4];
         int outv[$];
         int pendv = -1;
         for (int p = 0; p < 4; p++) begin
            case (d)
               2'd0: ci[p] = k*4 + p;
               2'd1: ci[p] = k*4 + (3-p);
               2'd2: ci[p] = p*4 + k;
               default: ci[p] = (3-p)*4 + k;
            endcase
         end
         for (int p = 0; p < 4; p++) begin
            int v = int'(b[ci[p]]);
            if (v != 0) begin
               if (pendv == v && v != 31) begin
                  outv.push_back(v + 1);
                  sc += longint'(1) << (v + 1);
                  pendv = -1;
               end else begin
                  if (pendv > 0) outv.push_back(pendv);
                  pendv = v;
               end
            end
         end
         if (pendv > 0) outv.push_back(pendv);
         for (int p = 0; p < 4; p++)
            r.b[ci[p]] = (p < outv.size()) ? 5'(outv[p]) : 5'd0;
      end
      r.sc  = (sc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(sc);
      r.mx  = '0;
      for (int i = 0; i < 16; i++) if (r.b[i] > r.mx) r.mx = r.b[i];
      r.mov = (r.b != b);
      return r;
   endfunction

   // Independent acceptance tracker: ph 1..4 line cycles, 5 = done cycle.
   always @(posedge clk) begin
      if (rst) begin
         ph = 0;
         sbq.delete();
         last = '{default: '0};
      end else if (ph == 0) begin
         if (start) begin
            sbq.push_back(pend);
            ph = 1;
            n_acc++;
         end
      end else if (ph == 5) begin
         if (sbq.size() > 0) last = sbq.pop_front();
         ph = 0;
      end else begin
         ph++;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("busy", 80'(busy), 80'(ph >= 1 && ph <= 4));
         chk("done", 80'(done), 80'(ph == 5));
         if (ph == 5) begin
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_empty: done with no expected result");
            end else begin
               chk("board_out", board_out, sbq[0].b);
               chk("movable", 80'(movable), 80'(sbq[0].mov));
               chk("score_gain", 80'(score_gain), 80'(sbq[0].sc));
               chk("max_tile", 80'(max_tile), 80'(sbq[0].mx));
            end
         end else begin
            chk("hold_board", board_out, last.b);
            chk("hold_max", 80'(max_tile), 80'(last.mx));
            if (ph == 0) begin
               chk("hold_mov", 80'(movable), 80'(last.mov));
               chk("hold_score", 80'(score_gain), 80'(last.sc));
            end
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         if (ph == 0) return;
         @(negedge clk);
      end
      n_cmp++; n_bad++;
      $display("FAIL timeout_idle: ph=%0d want 0", ph);
   endtask

   task automatic run_vec(input vec_t v);
      wait_idle();
      start = 1'b1; dir = v.d; board_in = v.bin; pend = v.exp;
      @(negedge clk);
      start = 1'b0;
      board_in = {$urandom, $urandom, 16'($urandom)};
      dir = 2'($urandom);
      @(negedge clk);
      wait_idle();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_busy"}, 80'(busy), 80'(0));
      chk({nm, "_done"}, 80'(done), 80'(0));
      chk({nm, "_board"}, board_out, 80'(0));
      chk({nm, "_mov"}, 80'(movable), 80'(0));
      chk({nm, "_score"}, 80'(score_gain), 80'(0));
      chk({nm, "_max"}, 80'(max_tile), 80'(0));
   endtask

   initial begin
      // Table of directed vectors with hand-derived expectations.
      for (int i = 0; i < 9; i++) begin
         tv[i].bin = '0;
         tv[i].exp = '{b: '0, mov: 1'b1, sc: 32'd0, mx: 5'd0};
      end
      tv[0].d = 2'd0; tv[0].bin[0] = 1; tv[0].bin[1] = 1; tv[0].bin[2] = 2; tv[0].bin[3] = 2;
      tv[0].exp.b[0] = 2; tv[0].exp.b[1] = 3; tv[0].exp.sc = 12; tv[0].exp.mx = 3;
      tv[1].d = 2'd1; tv[1].bin[0] = 1; tv[1].bin[3] = 1;
      tv[1].exp.b[3] = 2; tv[1].exp.sc = 4; tv[1].exp.mx = 2;
      tv[2].d = 2'd2;
      for (int r = 0; r < 4; r++) tv[2].bin[r*4+2] = 1;
      tv[2].exp.b[2] = 2; tv[2].exp.b[6] = 2; tv[2].exp.sc = 8; tv[2].exp.mx = 2;
      tv[3].d = 2'd0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) tv[3].bin[r*4+c] = 5'(r + c + 1);
      tv[3].exp.b = tv[3].bin; tv[3].exp.mov = 1'b0; tv[3].exp.mx = 7;
      tv[4].d = 2'd3; tv[4].bin[0] = 31; tv[4].bin[4] = 31;
      tv[4].exp.b[8] = 31; tv[4].exp.b[12] = 31; tv[4].exp.mx = 31;
      tv[5].d = 2'd0; tv[5].bin[4] = 2; tv[5].bin[5] = 1; tv[5].bin[6] = 1;
      tv[5].exp.b[4] = 2; tv[5].exp.b[5] = 2; tv[5].exp.sc = 4; tv[5].exp.mx = 2;
      tv[6].d = 2'd0;
      for (int i = 0; i < 16; i++) tv[6].bin[i] = 30;
      for (int r = 0; r < 4; r++) begin tv[6].exp.b[r*4] = 31; tv[6].exp.b[r*4+1] = 31; end
      tv[6].exp.sc = 32'hFFFF_FFFF; tv[6].exp.mx = 31;
      tv[7].d = 2'd2; tv[7].exp.mov = 1'b0;
      tv[8].d = 2'd1; tv[8].bin[8] = 3; tv[8].bin[9] = 3; tv[8].bin[10] = 3;
      tv[8].exp.b[11] = 4; tv[8].exp.b[10] = 3; tv[8].exp.sc = 16; tv[8].exp.mx = 4;

      // Reset held with start asserted: reset must win.
      rst = 1'b1; start = 1'b1; dir = 2'd0; board_in = '1; pend = tv[0].exp;
      repeat (3) @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk_zero("reset");
      mon_en = 1;

      foreach (tv[i]) run_vec(tv[i]);

      // Start pulsed two cycles into a run is ignored.
      wait_idle();
      start = 1'b1; dir = tv[1].d; board_in = tv[1].bin; pend = tv[1].exp;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1; board_in = tv[6].bin; dir = 2'd3;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      wait_idle();

      // Reset in the middle of a run aborts it.
      start = 1'b1; dir = tv[0].d; board_in = tv[0].bin; pend = tv[0].exp;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk_zero("abort");
      run_vec(tv[2]);

      // Start held high: runs back to back, fresh board each run.
      wait_idle();
      for (int r = 0; r < 6; r++) begin
         brd_t rb;
         logic [1:0] d;
         int tgt;
         for (int i = 0; i < 16; i++) rb[i] = 5'($urandom_range(0, 3));
         d = 2'($urandom_range(0, 3));
         pend = model(rb, d);
         board_in = rb; dir = d; start = 1'b1;
         tgt = n_acc + 1;
         for (int i = 0; i < 20 && n_acc < tgt; i++) @(negedge clk);
         if (n_acc < tgt) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout_accept: acc=%0d want %0d", n_acc, tgt);
         end
      end
      start = 1'b0;
      @(negedge clk);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("sb_drained", 80'(sbq.size()), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
